// File: rtl/uart_tx_pkg.sv
// Shared constants and helpers for the UART TX datapath blocks.
package uart_tx_pkg;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity of a data word, even or odd as selected.
module uart_parity_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_odd,
    output logic                  parity
);

    assign parity = (par_odd == PAR_EVEN) ? (^data) : (~^data);

endmodule

// File: rtl/uart_tx_piso_buffered.sv
// Double-buffered PISO for the UART TX path: one-word holding register
// feeding a shifter that emits one bit per ser_en strobe.
//
// state         | hold_valid ser_busy | meaning
// EMPTY         | 0 0                 | nothing held, shifter idle, ready
// HELD          | 1 0                 | word waiting, moves to shifter next edge
// SHIFTING      | 0 1                 | word being serialised, ready for next
// SHIFTING_HELD | 1 1                 | shifting with next word queued, not ready
module uart_tx_piso_buffered
    import uart_tx_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    localparam int CNT_W      = clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  msb_first,
    input  logic                  par_odd,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  ser_busy,
    output logic                  ser_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_msb;
    logic                  hold_par;
    logic                  hold_parity;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  shift_msb;
    logic [CNT_W-1:0]      bit_cnt;

    logic accept;
    logic transfer;
    logic complete;
    logic shift;

    assign Data_Ready = !hold_valid;
    assign accept     = Data_Valid && Data_Ready;
    assign transfer   = hold_valid && !ser_busy;
    assign complete   = ser_busy && (bit_cnt == CNT_LAST);
    assign shift      = ser_busy && ser_en && (bit_cnt < CNT_LAST);

    uart_parity_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (hold_data),
        .par_odd(hold_par),
        .parity (hold_parity)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_msb   <= 1'b0;
            hold_par   <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= P_DATA;
            hold_msb   <= msb_first;
            hold_par   <= par_odd;
        end else if (transfer) begin
            hold_valid <= 1'b0;
        end
    end

    // Completion is checked before shifting so a strobe on the done cycle is dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg <= '0;
            shift_msb <= 1'b0;
            bit_cnt   <= '0;
            ser_busy  <= 1'b0;
            ser_done  <= 1'b0;
            ser_data  <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            ser_done <= 1'b0;
            if (transfer) begin
                shift_reg <= hold_data;
                shift_msb <= hold_msb;
                par_bit   <= hold_parity;
                bit_cnt   <= '0;
                ser_busy  <= 1'b1;
            end else if (complete) begin
                ser_done <= 1'b1;
                ser_busy <= 1'b0;
                bit_cnt  <= '0;
            end else if (shift) begin
                ser_data  <= (shift_msb == ORDER_MSB) ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
                shift_reg <= (shift_msb == ORDER_LSB) ? {1'b0, shift_reg[DATA_WIDTH-1:1]}
                                                      : {shift_reg[DATA_WIDTH-2:0], 1'b0};
                bit_cnt   <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_piso_buffered.sv
// Self-checking bench: queue-based behavioural model compared every cycle,
// plus directed words with hand-computed bit sequences.
module tb_uart_tx_piso_buffered;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          Data_Ready;
    logic          msb_first = 1'b0;
    logic          par_odd = 1'b0;
    logic          ser_en = 1'b0;
    logic          ser_data;
    logic          par_bit;
    logic          ser_busy;
    logic          ser_done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    uart_tx_piso_buffered #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready),
        .msb_first (msb_first),
        .par_odd   (par_odd),
        .ser_en    (ser_en),
        .ser_data  (ser_data),
        .par_bit   (par_bit),
        .ser_busy  (ser_busy),
        .ser_done  (ser_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one optional held word, and the remaining bits of
    // the word in the shifter as a plain queue in transmission order.
    bit          m_hold_valid = 1'b0;
    bit [DW-1:0] m_h_word = '0;
    bit          m_h_msb = 1'b0;
    bit          m_h_odd = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_bits[$];
    bit          m_ser = 1'b0;
    bit          m_par = 1'b0;
    bit          m_done = 1'b0;

    always @(posedge CLK or negedge RST) begin : model
        bit acc, xfer, cmpl, shf;
        if (!RST) begin
            m_hold_valid = 1'b0;
            m_busy = 1'b0;
            m_bits.delete();
            m_ser = 1'b0;
            m_par = 1'b0;
            m_done = 1'b0;
        end else begin
            acc  = Data_Valid && !m_hold_valid;
            xfer = m_hold_valid && !m_busy;
            cmpl = m_busy && (m_bits.size() == 0);
            shf  = m_busy && ser_en && (m_bits.size() != 0);
            m_done = cmpl;
            if (cmpl) m_busy = 1'b0;
            if (shf) m_ser = m_bits.pop_front();
            if (xfer) begin
                m_bits.delete();
                for (int i = 0; i < DW; i++)
                    m_bits.push_back(m_h_msb ? m_h_word[DW-1-i] : m_h_word[i]);
                m_par = (($countones(m_h_word) % 2) == 1) ^ m_h_odd;
                m_busy = 1'b1;
                m_hold_valid = 1'b0;
            end
            if (acc) begin
                m_h_word = P_DATA;
                m_h_msb = msb_first;
                m_h_odd = par_odd;
                m_hold_valid = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_ready", Data_Ready, !m_hold_valid);
            check("cyc_busy", ser_busy, m_busy);
            check("cyc_done", ser_done, m_done);
            check("cyc_ser_data", ser_data, m_ser);
            check("cyc_par_bit", par_bit, m_par);
        end
    end

    task automatic cyc(input bit dv, input logic [DW-1:0] d, input bit m, input bit p, input bit en);
        Data_Valid = dv;
        P_DATA = d;
        msb_first = m;
        par_odd = p;
        ser_en = en;
        @(posedge CLK);
        #2;
    endtask

    task automatic word_test(input logic [DW-1:0] w, input bit m, input bit p,
                             input logic [DW-1:0] exp_seq, input bit exp_par);
        logic [DW-1:0] seq;
        seq = '0;
        cyc(1, w, m, p, 0);
        check("word_held_not_ready", Data_Ready, 1'b0);
        cyc(0, '0, 0, 0, 0);
        check("word_transferred_busy", ser_busy, 1'b1);
        check("word_par_bit", par_bit, exp_par);
        check("word_ready_again", Data_Ready, 1'b1);
        for (int i = 0; i < DW; i++) begin
            cyc(0, '0, 0, 0, 1);
            seq[i] = ser_data;
            if (i < DW - 1) cyc(0, '0, 0, 0, 0);
        end
        check("word_no_early_done", ser_done, 1'b0);
        cyc(0, '0, 0, 0, 1);
        check("word_done_pulse", ser_done, 1'b1);
        check("word_idle_after_done", ser_busy, 1'b0);
        check("word_no_extra_shift", ser_data, exp_seq[DW-1]);
        cyc(0, '0, 0, 0, 0);
        check("word_done_one_cycle", ser_done, 1'b0);
        check("word_bit_sequence", seq, exp_seq);
        check("word_par_held", par_bit, exp_par);
    endtask

    initial begin : stim
        int done_seen;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_ready", Data_Ready, 1'b1);
        check("rst_busy", ser_busy, 1'b0);
        check("rst_done", ser_done, 1'b0);
        check("rst_ser_data", ser_data, 1'b0);
        check("rst_par_bit", par_bit, 1'b0);
        RST = 1'b1;
        chk_en = 1'b1;

        repeat (3) cyc(0, '0, 0, 0, 1);
        check("idle_strobe_ser_data", ser_data, 1'b0);
        check("idle_strobe_busy", ser_busy, 1'b0);

        // 0xB1 LSB-first: 1,0,0,0,1,1,0,1 -> 8'hB1; even parity 0
        word_test(8'hB1, 0, 0, 8'hB1, 1'b0);
        // 0xB1 MSB-first: 1,0,1,1,0,0,0,1 -> 8'h8D; odd parity 1
        word_test(8'hB1, 1, 1, 8'h8D, 1'b1);

        // back-to-back with a third word pending on Data_Valid
        cyc(1, 8'h0F, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        cyc(1, 8'hF0, 1, 1, 0);
        check("b2b_second_held", Data_Ready, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1, 8'h3C, 0, 1, (i % 2) == 0);
        for (int i = 0; i < 60; i++) cyc(0, '0, 0, 0, (i % 2) == 0);

        // reset mid-word with a held word
        cyc(1, 8'h55, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        repeat (3) cyc(0, '0, 0, 0, 1);
        cyc(1, 8'hA5, 1, 0, 0);
        RST = 1'b0;
        #1;
        check("mid_rst_ready", Data_Ready, 1'b1);
        check("mid_rst_busy", ser_busy, 1'b0);
        check("mid_rst_done", ser_done, 1'b0);
        check("mid_rst_ser_data", ser_data, 1'b0);
        check("mid_rst_par_bit", par_bit, 1'b0);
        #1;
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        RST = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, '0, 0, 0, $urandom_range(0, 1) == 1);
            if (ser_done) done_seen++;
        end
        check("post_rst_no_done", done_seen, 0);
        check("post_rst_ready", Data_Ready, 1'b1);

        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        for (int i = 0; i < 60; i++) cyc(0, '0, 0, 0, 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
